dht11_reader: RTL and testbench

- Single-wire DHT11 bus master. Sits directly upstream of the decimal digit-split stage and feeds its 32-bit `information` input.
- Periodically issues a start pulse, captures the sensor's 40-bit frame and verifies the checksum.
- Publishes the upper 32 bits (humidity int/dec, temperature int/dec) only when a frame is valid.

---
 rtl/dht11_reader.sv | 200 ++++++++++++++++++++
 tb/tb_dht11_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire bus master: polls the sensor, captures the 40-bit frame and publishes the checksum-verified upper 32 bits.
// Optional build macro DHT_ERR_CNT_EN adds err_cnt, a saturating count of checksum and timeout errors.
`timescale 1ns/1ps
module dht11_reader #(
  parameter int CLK_MHZ        = 50,
  parameter int POLL_PERIOD_MS = 2000,
  parameter int START_LOW_MS   = 20,
  parameter int TIMEOUT_US     = 200,
  parameter int BIT_THRESH_US  = 50
) (
  input  logic        clk,
  input  logic        rstn,
  inout  wire         dht_io,
  output logic [31:0] information,
  output logic        data_valid,
  output logic        busy,
  output logic        checksum_err,
  output logic        timeout_err,
`ifdef DHT_ERR_CNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic [3:0]  dbg_state
);

  localparam int PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_WAIT_RESP = 4'd2,
    ST_RESP_LOW  = 4'd3,
    ST_RESP_HIGH = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7
  } state_t;

  state_t      state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [31:0] info_q, info_d;
  logic        valid_q, valid_d;
  logic        cks_q, cks_d;
  logic        tmo_q, tmo_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        us_tick, rise, fall, wait_timeout, counting_ms;
  logic [7:0]  sum;

  // The DUT only ever pulls low; a high level comes from the external pull-up.
  assign dht_io = (state_q == ST_START_LOW) ? 1'b0 : 1'bz;

  assign rise         = sync2_q & ~prev_q;
  assign fall         = ~sync2_q & prev_q;
  assign us_tick      = (pre_q == PRE_W'(CLK_MHZ - 1));
  assign pre_d        = us_tick ? '0 : pre_q + 1'b1;
  assign wait_timeout = (us_cnt_q >= 16'(TIMEOUT_US));
  assign counting_ms  = (state_q == ST_IDLE) || (state_q == ST_START_LOW);
  assign sum          = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      info_q    <= '0;
      valid_q   <= 1'b0;
      cks_q     <= 1'b0;
      tmo_q     <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      us_cnt_q  <= us_cnt_d;
      ms_cnt_q  <= ms_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      info_q    <= info_d;
      valid_q   <= valid_d;
      cks_q     <= cks_d;
      tmo_q     <= tmo_d;
      sync1_q   <= dht_io;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  // Next state. In every wait state an edge is tested before the timeout, so the edge wins a tie.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    info_d    = info_q;
    valid_d   = 1'b0;
    cks_d     = 1'b0;
    tmo_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ms_cnt_q >= 16'(POLL_PERIOD_MS)) state_d = ST_START_LOW;
      end
      ST_START_LOW: begin
        if (ms_cnt_q >= 16'(START_LOW_MS)) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (fall) state_d = ST_RESP_LOW;
        else if (wait_timeout) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_RESP_LOW: begin
        if (rise) state_d = ST_RESP_HIGH;
        else if (wait_timeout) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_RESP_HIGH: begin
        if (fall) begin
          state_d   = ST_BIT_LOW;
          bit_cnt_d = '0;
        end else if (wait_timeout) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_BIT_LOW: begin
        if (rise) state_d = ST_BIT_HIGH;
        else if (wait_timeout) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_BIT_HIGH: begin
        if (fall) begin
          shift_d   = {shift_q[38:0], (us_cnt_q > 16'(BIT_THRESH_US))};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? ST_CHECK : ST_BIT_LOW;
        end else if (wait_timeout) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (sum == shift_q[7:0]) begin
          info_d  = shift_q[39:8];
          valid_d = 1'b1;
        end else begin
          cks_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // us counter restarts on every state entry; IDLE and START_LOW roll it into a ms count.
  always_comb begin
    us_cnt_d = us_cnt_q;
    ms_cnt_d = ms_cnt_q;
    if (state_d != state_q) begin
      us_cnt_d = '0;
      ms_cnt_d = '0;
    end else if (us_tick) begin
      if (counting_ms && (us_cnt_q == 16'd999)) begin
        us_cnt_d = '0;
        ms_cnt_d = ms_cnt_q + 16'd1;
      end else if (us_cnt_q != 16'hFFFF) begin
        us_cnt_d = us_cnt_q + 16'd1;
      end
    end
  end

`ifdef DHT_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) err_cnt_q <= '0;
    else if ((cks_d || tmo_d) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

  // data_valid qualifies information for exactly one cycle; there is no ready, the consumer must take it then.
  assign information  = info_q;
  assign data_valid   = valid_q;
  assign checksum_err = cks_q;
  assign timeout_err  = tmo_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a timed DHT11 sensor model drives the bus; expected pulses go to a queue checked by a monitor.
`timescale 1ns/1ps
module tb_dht11_reader;

  localparam int CLK_MHZ = 2;
  localparam int HALF_NS = 1000 / (2 * CLK_MHZ);
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_CKS   = 2'd1;
  localparam logic [1:0] K_TMO   = 2'd2;

  // clock / reset / bus
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sens_low = 1'b0;
  wire         dht_line;
  logic [31:0] information;
  logic        data_valid, busy, checksum_err, timeout_err;
  logic [3:0]  dbg_state;
`ifdef DHT_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  pullup (dht_line);
  assign dht_line = sens_low ? 1'b0 : 1'bz;

  always #(HALF_NS) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_reader #(
    .CLK_MHZ(CLK_MHZ), .POLL_PERIOD_MS(1), .START_LOW_MS(1),
    .TIMEOUT_US(200), .BIT_THRESH_US(50)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .dht_io(dht_line),
    .information(information),
    .data_valid(data_valid),
    .busy(busy),
    .checksum_err(checksum_err),
    .timeout_err(timeout_err),
`ifdef DHT_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [33:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // monitor: every result pulse pops one expectation
  logic [1:0]  mon_kind;
  logic [33:0] mon_exp;
  always @(negedge clk) begin
    if (rstn && (data_valid || checksum_err || timeout_err)) begin
      check("pulse_exclusive", 64'(int'(data_valid) + int'(checksum_err) + int'(timeout_err)), 64'd1);
      mon_kind = data_valid ? K_VALID : (checksum_err ? K_CKS : K_TMO);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind=%0d info=0x%08h expected none", mon_kind, information);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse_kind_info", {30'd0, mon_kind, information}, {30'd0, mon_exp});
      end
    end
  end

  // driver tasks
  task automatic us_delay(input int n);
    #(n * 1000);
  endtask

  task automatic wait_line(input logic level, input int max_us, input string what);
    bit ok = 1'b0;
    for (int i = 0; i < max_us * CLK_MHZ; i++) begin
      @(negedge clk);
      if (dht_line === level) begin
        ok = 1'b1;
        break;
      end
    end
    check(what, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_busy_low(input int max_us, input string what);
    bit ok = 1'b0;
    for (int i = 0; i < max_us * CLK_MHZ; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(what, {63'd0, ok}, 64'd1);
  endtask

  // waits for the master's start pulse and measures its width
  task automatic wait_start(input string what, output int fall_cyc);
    wait_line(1'b0, 3000, {what, "_start_seen"});
    fall_cyc = cyc;
    check({what, "_busy_in_start"}, {63'd0, busy}, 64'd1);
    wait_line(1'b1, 2000, {what, "_start_release"});
    check_range({what, "_start_low_us"}, (cyc - fall_cyc) / CLK_MHZ, 995, 1005);
  endtask

  // sensor answer: 80 us low, 80 us high, then nbits of 10 us low + 26/70 us high
  task automatic send_frame(input logic [39:0] f, input int nbits, input bit finish);
    us_delay(20);
    sens_low = 1'b1; us_delay(80);
    sens_low = 1'b0; us_delay(80);
    for (int i = 0; i < nbits; i++) begin
      sens_low = 1'b1; us_delay(10);
      sens_low = 1'b0; us_delay(f[39 - i] ? 70 : 26);
    end
    if (finish) begin
      sens_low = 1'b1; us_delay(10);
      sens_low = 1'b0;
    end
  endtask

  int rst_cyc, fall_cyc, t0;

  initial begin
    // reset state
    repeat (5) @(negedge clk);
    check("rst_information", 64'(information), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_pulses", {61'd0, data_valid, checksum_err, timeout_err}, 64'd0);
    check("rst_line_released", {63'd0, dht_line}, 64'd1);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    rstn = 1'b1;
    rst_cyc = cyc;

    // good frame 37 00 1A 03 / 54
    wait_start("t1", fall_cyc);
    check_range("t1_first_start_us", (fall_cyc - rst_cyc) / CLK_MHZ, 995, 1005);
    exp_q.push_back({K_VALID, 32'h37001A03});
    send_frame(40'h37001A0354, 40, 1'b1);
    wait_busy_low(200, "t1_busy_falls");
    repeat (3) @(negedge clk);
    check("t1_information", 64'(information), 64'h37001A03);

    // bad checksum: information held
    wait_start("t2", fall_cyc);
    exp_q.push_back({K_CKS, 32'h37001A03});
    send_frame(40'h37001A0355, 40, 1'b1);
    wait_busy_low(200, "t2_busy_falls");
    repeat (3) @(negedge clk);
    check("t2_information_held", 64'(information), 64'h37001A03);

    // no response: timeout 200 us after release, then re-poll 1 ms later
    wait_start("t3", fall_cyc);
    t0 = cyc;
    exp_q.push_back({K_TMO, 32'h37001A03});
    wait_busy_low(400, "t3_busy_falls");
    check_range("t3_timeout_us", (cyc - t0) / CLK_MHZ, 197, 203);
    check("t3_line_released", {63'd0, dht_line}, 64'd1);
    t0 = cyc;

    // stop after 17 bits with line high: BIT_HIGH timeout
    wait_start("t4", fall_cyc);
    check_range("t3_repoll_us", (fall_cyc - t0) / CLK_MHZ, 997, 1003);
    exp_q.push_back({K_TMO, 32'h37001A03});
    send_frame(40'h37001A0354, 17, 1'b0);
    wait_busy_low(400, "t4_busy_falls");
    repeat (3) @(negedge clk);
    check("t4_information_held", 64'(information), 64'h37001A03);

    // bit boundary frame FF 00 00 00 / FF
    wait_start("t5", fall_cyc);
    exp_q.push_back({K_VALID, 32'hFF000000});
    send_frame(40'hFF000000FF, 40, 1'b1);
    wait_busy_low(200, "t5_busy_falls");
    repeat (3) @(negedge clk);
    check("t5_information", 64'(information), 64'hFF000000);

    // reset during the high phase of bit 20
    wait_start("t6", fall_cyc);
`ifdef DHT_ERR_CNT_EN
    check("err_cnt_three", 64'(err_cnt), 64'd3);
`endif
    send_frame(40'h37001A0354, 19, 1'b0);
    sens_low = 1'b1; us_delay(10);
    sens_low = 1'b0; us_delay(10);
    check("t6_busy_mid_frame", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rst_cyc = cyc;
    check("t6_rst_line_released", {63'd0, dht_line}, 64'd1);
    check("t6_rst_information", 64'(information), 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_pulses", {61'd0, data_valid, checksum_err, timeout_err}, 64'd0);
    check("t6_rst_state_idle", 64'(dbg_state), 64'd0);
`ifdef DHT_ERR_CNT_EN
    check("err_cnt_cleared", 64'(err_cnt), 64'd0);
`endif
    wait_start("t7", fall_cyc);
    check_range("t7_start_after_reset_us", (fall_cyc - rst_cyc) / CLK_MHZ, 995, 1005);
    exp_q.push_back({K_TMO, 32'h00000000});
    wait_busy_low(400, "t7_busy_falls");
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
